hilo_reg_unit: RTL and testbench

//  HI/LO special-register stage directly downstream of the 32x32 multiplier.
//  - Captures the 64-bit product {mul_hi,mul_lo} on issue.
//  - Models multiplier latency with a countdown, then commits the product to HI/LO.
//  - Services MTHI/MTLO writes and MFHI/MFLO reads, with a stall interlock while a result is pending.

---
 rtl/hilo_pkg.sv | 26 ++
 rtl/hilo_reg_unit_if.sv | 30 +++
 rtl/hilo_lat_counter.sv | 27 ++
 rtl/hilo_reg_unit.sv | 106 ++++++++++
 tb/tb_hilo_reg_unit.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/hilo_pkg.sv
// Shared constants, state encoding and payload types for the HI/LO register stage.
// Optional feature macro: HILO_MADD_EN (accumulate-on-commit, MADD/MADDU).
package hilo_pkg;

   localparam int unsigned HILO_W = 32;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned PAIR_W = 2 * HILO_W;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } hilo_state_e;

   typedef struct packed {
      logic [HILO_W-1:0] hi;
      logic [HILO_W-1:0] lo;
   } hilo_pair_t;

   // 64-bit wrapping add of two HI/LO pairs; no carry-out is kept
   function automatic hilo_pair_t hilo_add(input hilo_pair_t a, input hilo_pair_t b);
      logic [PAIR_W-1:0] sum;
      sum = PAIR_W'(a) + PAIR_W'(b);
      return hilo_pair_t'(sum);
   endfunction

endpackage

// File: rtl/hilo_reg_unit_if.sv
// Request/response bundle between the pipeline and the HI/LO register stage.
interface hilo_reg_unit_if;
   import hilo_pkg::*;

   logic              mul_go;
   logic [HILO_W-1:0] mul_hi;
   logic [HILO_W-1:0] mul_lo;
   logic              mul_acc;
   logic              mthi;
   logic              mtlo;
   logic [HILO_W-1:0] wr_data;
   logic              rd_req;
   logic              rd_sel;
   logic [HILO_W-1:0] rd_data;
   logic [HILO_W-1:0] hi;
   logic [HILO_W-1:0] lo;
   logic              busy;
   logic              stall;

   modport master (
      output mul_go, mul_hi, mul_lo, mul_acc, mthi, mtlo, wr_data, rd_req, rd_sel,
      input  rd_data, hi, lo, busy, stall
   );

   modport slave (
      input  mul_go, mul_hi, mul_lo, mul_acc, mthi, mtlo, wr_data, rd_req, rd_sel,
      output rd_data, hi, lo, busy, stall
   );

endinterface

// File: rtl/hilo_lat_counter.sv
// Multiplier-latency countdown: load on issue, decrement to zero, flag the final cycle.
module hilo_lat_counter #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done_c
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   // High during the cycle whose closing edge commits the product
   assign done_c = (cnt == CNT_W'(1));

endmodule

// File: rtl/hilo_reg_unit.sv
// HI/LO special-register stage downstream of the 32x32 multiplier.
// Optional feature macro: HILO_MADD_EN enables accumulate-on-commit via mul_acc.
module hilo_reg_unit
   import hilo_pkg::*;
#(
   parameter int unsigned LATENCY = 4
) (
   input  logic            clk,
   input  logic            reset,
   hilo_reg_unit_if.slave  io
);

   hilo_state_e state_q, state_d;
   hilo_pair_t  hilo_q, hilo_d;
   hilo_pair_t  prod_q, prod_d;
   hilo_pair_t  commit_val;
   logic        cnt_load;
   logic        cnt_done_c;
   logic        busy;

   hilo_lat_counter #(
      .CNT_W (CNT_W)
   ) u_lat_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (CNT_W'(LATENCY)),
      .done_c   (cnt_done_c)
   );

`ifdef HILO_MADD_EN
   logic acc_q, acc_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
      end
   end

   // Accumulate uses HI/LO as they stand at the commit edge
   assign commit_val = acc_q ? hilo_add(hilo_q, prod_q) : prod_q;
`else
   logic mul_acc_unused;

   assign mul_acc_unused = io.mul_acc;
   assign commit_val     = prod_q;
`endif

   // State, product capture and HI/LO flops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         hilo_q  <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         hilo_q  <= hilo_d;
         prod_q  <= prod_d;
      end
   end

   // Next-state: MT writes and issue only in IDLE; BUSY just waits for the commit
   always_comb begin
      state_d  = state_q;
      hilo_d   = hilo_q;
      prod_d   = prod_q;
      cnt_load = 1'b0;
`ifdef HILO_MADD_EN
      acc_d    = acc_q;
`endif
      case (state_q)
         IDLE: begin
            if (io.mthi) begin
               hilo_d.hi = io.wr_data;
            end
            if (io.mtlo) begin
               hilo_d.lo = io.wr_data;
            end
            if (io.mul_go) begin
               prod_d   = hilo_pair_t'({io.mul_hi, io.mul_lo});
               cnt_load = 1'b1;
               state_d  = BUSY;
`ifdef HILO_MADD_EN
               acc_d    = io.mul_acc;
`endif
            end
         end
         BUSY: begin
            if (cnt_done_c) begin
               hilo_d  = commit_val;
               state_d = IDLE;
            end
         end
      endcase
   end

   assign busy       = (state_q == BUSY);
   assign io.busy    = busy;
   assign io.stall   = busy & (io.mul_go | io.mthi | io.mtlo | io.rd_req);
   assign io.hi      = hilo_q.hi;
   assign io.lo      = hilo_q.lo;
   assign io.rd_data = io.rd_sel ? hilo_q.hi : hilo_q.lo;

endmodule

// File: tb/tb_hilo_reg_unit.sv
// Randomised and directed bench for hilo_reg_unit against a cycle-indexed behavioural model.
module tb_hilo_reg_unit;
   import hilo_pkg::*;

   localparam int unsigned LAT = 4;
`ifdef HILO_MADD_EN
   localparam bit MADD = 1'b1;
`else
   localparam bit MADD = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   hilo_reg_unit_if io();

   hilo_reg_unit #(.LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (io)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Model: architectural HI/LO pair plus one pending product with its commit edge index
   logic [63:0] m_hilo;
   logic [63:0] m_prod;
   logic        m_acc;
   logic        m_busy;
   int          m_commit;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_clear();
      m_hilo   = '0;
      m_prod   = '0;
      m_acc    = 1'b0;
      m_busy   = 1'b0;
      m_commit = 0;
   endtask

   task automatic step(input logic go, input logic [31:0] ph, input logic [31:0] pl,
                       input logic acc, input logic th, input logic tl,
                       input logic [31:0] wd, input logic rq, input logic rs);
      logic [31:0] exp_rd;
      @(negedge clk);
      io.mul_go  = go;
      io.mul_hi  = ph;
      io.mul_lo  = pl;
      io.mul_acc = acc;
      io.mthi    = th;
      io.mtlo    = tl;
      io.wr_data = wd;
      io.rd_req  = rq;
      io.rd_sel  = rs;
      #1;
      exp_rd = rs ? m_hilo[63:32] : m_hilo[31:0];
      chk("hi",      64'(io.hi),      64'(m_hilo[63:32]));
      chk("lo",      64'(io.lo),      64'(m_hilo[31:0]));
      chk("busy",    64'(io.busy),    64'(m_busy));
      chk("stall",   64'(io.stall),   64'(m_busy & (go | th | tl | rq)));
      chk("rd_data", 64'(io.rd_data), 64'(exp_rd));
      @(posedge clk);
      cyc++;
      if (m_busy) begin
         if (cyc == m_commit) begin
            m_hilo = m_acc ? (m_hilo + m_prod) : m_prod;
            m_busy = 1'b0;
         end
      end else begin
         if (th) m_hilo[63:32] = wd;
         if (tl) m_hilo[31:0]  = wd;
         if (go) begin
            m_prod   = {ph, pl};
            m_acc    = MADD & acc;
            m_busy   = 1'b1;
            m_commit = cyc + int'(LAT);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic issue(input logic [31:0] ph, input logic [31:0] pl, input logic acc);
      step(1'b1, ph, pl, acc, 1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      io.mul_go = 1'b0; io.mul_hi = '0; io.mul_lo = '0; io.mul_acc = 1'b0;
      io.mthi = 1'b0; io.mtlo = 1'b0; io.wr_data = '0; io.rd_req = 1'b0; io.rd_sel = 1'b0;
      model_clear();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_hi",    64'(io.hi),    64'h0);
      chk("rst_lo",    64'(io.lo),    64'h0);
      chk("rst_busy",  64'(io.busy),  64'h0);
      chk("rst_stall", 64'(io.stall), 64'h0);
      @(negedge clk);
      reset = 1'b0;

      // Reset while a product is pending discards it
      issue(32'h0000_0001, 32'h0000_0000, 1'b0);
      idle(2);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_hi",   64'(io.hi),   64'h0);
      chk("midrst_lo",   64'(io.lo),   64'h0);
      chk("midrst_busy", 64'(io.busy), 64'h0);
      model_clear();
      @(negedge clk);
      reset = 1'b0;
      idle(6);
      #1;
      chk("midrst_nocommit", {32'(io.hi), 32'(io.lo)}, 64'h0);

      // Basic multiply with the stated latency
      issue(32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
      idle(3);
      #1;
      chk("t2_busy_e3", 64'(io.busy), 64'h1);
      idle(1);
      #1;
      chk("t2_busy_e4", 64'(io.busy), 64'h0);
      chk("t2_hilo", {32'(io.hi), 32'(io.lo)}, 64'h0000_0001_FFFF_FFFE);

      // Held MFHI during busy reads the freshly committed value
      issue(32'h0000_0001, 32'h0000_0055, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
      #1;
      chk("t3_rd",    64'(io.rd_data), 64'h0000_0001);
      chk("t3_stall", 64'(io.stall),   64'h0);
      idle(1);

      // MT ops in IDLE and rejected during busy
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      #1;
      chk("t4_hilo", {32'(io.hi), 32'(io.lo)}, 64'hDEAD_BEEF_DEAD_BEEF);
      issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);
      #1;
      chk("t4_lo_kept", 64'(io.lo), 64'h0000_0000_DEAD_BEEF);
      idle(4);

      // Second issue while busy is stalled, then accepted once busy drops
      issue(32'h0000_000A, 32'h0000_000B, 1'b0);
      for (int i = 0; i < 4; i++) issue(32'h0000_000C, 32'h0000_000D, 1'b0);
      #1;
      chk("t5_first", {32'(io.hi), 32'(io.lo)}, 64'h0000_000A_0000_000B);
      issue(32'h0000_000C, 32'h0000_000D, 1'b0);
      idle(4);
      #1;
      chk("t5_second", {32'(io.hi), 32'(io.lo)}, 64'h0000_000C_0000_000D);

      // Accumulate wraps mod 2^64 when enabled, plain overwrite otherwise
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      issue(32'h0000_0000, 32'h0000_0002, 1'b1);
      idle(4);
      #1;
      chk("t6_acc", {32'(io.hi), 32'(io.lo)}, MADD ? 64'h0000_0000_0000_0001 : 64'h0000_0000_0000_0002);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 3) == 0), $urandom, $urandom, 1'($urandom),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), $urandom,
              ($urandom_range(0, 2) == 0), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
